// File: rtl/rs_pkg.sv
// GF(2^8) helpers for the parallel Reed-Solomon syndrome block.
// Holds the field polynomial and width, a generic GF multiply, and the
// alpha-power function used to elaborate constant-coefficient multipliers.
// Every call with a constant operand folds down to a fixed XOR network.
package rs_pkg;

  localparam int         GF_W    = 8;
  localparam logic [8:0] GF_POLY = 9'h11D;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } rs_state_e;

  // Shift-and-add multiply.  When b is an elaboration constant, the unused
  // branches drop out and only an XOR network is left.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // alpha^e with alpha = 0x02; the exponent is reduced modulo the group order.
  function automatic logic [7:0] gf_alpha_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < (e % 255); i++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [7:0] gf_mul_const(input logic [7:0] value, input int exponent);
    return gf_mul(value, gf_alpha_pow(exponent));
  endfunction

endpackage

// File: rtl/rs_syn_cell.sv
// One syndrome accumulator: S <= B*alpha^(EXP*LANES) + sum_k d_k*alpha^(EXP*(LANES-1-k)).
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   data          - one beat, lane k in bits [8k+7:8k], lane 0 oldest
//   load          - a beat transfers this cycle
//   first         - beat is the first of a codeword (old accumulator ignored)
//   syn_next      - combinational updated syndrome, including the current beat
module rs_syn_cell
  import rs_pkg::*;
#(
  parameter int LANES = 16,
  parameter int EXP   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*LANES-1:0] data,
  input  logic               load,
  input  logic               first,
  output logic [7:0]         syn_next
);

  localparam logic [7:0] C_BEAT = gf_alpha_pow(EXP * LANES);

  logic [7:0]             acc;
  logic [LANES-1:0][7:0]  term;

  // Lane 0 is the highest power inside the beat, the last lane is degree 0.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam logic [7:0] C_LANE = gf_alpha_pow(EXP * (LANES - 1 - k));
    assign term[k] = gf_mul(data[8*k +: 8], C_LANE);
  end

  always_comb begin
    syn_next = first ? 8'h00 : gf_mul(acc, C_BEAT);
    for (int k = 0; k < LANES; k++) syn_next = syn_next ^ term[k];
  end

  always_ff @(posedge clk) begin
    if (rst)       acc <= '0;
    else if (load) acc <= syn_next;
  end

endmodule

// File: rtl/rs_syndrome_par.sv
// Beat-parallel Reed-Solomon syndrome calculator over GF(2^8), poly 0x11D.
// Accepts LANES symbols per beat (highest degree first) and reports NSYM
// syndromes one cycle after the last beat of each codeword.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   in_data/valid/last  - codeword beats, ready/valid handshake
//   in_ready            - beat accepted when in_valid && in_ready
//   out_syn             - syndrome j in bits [8j+7:8j]
//   out_err             - any syndrome nonzero
//   out_beats           - beats in the codeword, saturating
//   out_valid/out_ready - result handshake; result held while stalled
module rs_syndrome_par
  import rs_pkg::*;
#(
  parameter int LANES = 16,
  parameter int NSYM  = 16,
  parameter int FCR   = 0,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [8*NSYM-1:0]  out_syn,
  output logic               out_err,
  output logic [CNT_W-1:0]   out_beats,
  output logic               out_valid,
  input  logic               out_ready
);

  rs_state_e             state;
  logic                  xfer;
  logic                  first;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [NSYM-1:0][7:0]  syn_next;

  // A held result only blocks input when the consumer is not taking it now,
  // so a new result can load on the same edge the old one is consumed.
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;
  assign first    = (state == IDLE);
  assign cnt_next = first ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));

  for (genvar j = 0; j < NSYM; j++) begin : g_syn
    rs_syn_cell #(
      .LANES (LANES),
      .EXP   (FCR + j)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .data     (in_data),
      .load     (xfer),
      .first    (first),
      .syn_next (syn_next[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_syn   <= '0;
      out_err   <= 1'b0;
      out_beats <= '0;
    end else begin
      if (xfer) begin
        cnt   <= cnt_next;
        state <= in_last ? IDLE : ACCUM;
      end
      if (xfer && in_last) begin
        out_syn   <= syn_next;
        out_err   <= |syn_next;
        out_beats <= cnt_next;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_syndrome_par.sv
// Scoreboard bench for rs_syndrome_par (LANES=16, NSYM=16, FCR=0).
module tb_rs_syndrome_par;

  localparam int LANES = 16;
  localparam int NSYM  = 16;
  localparam int CNT_W = 8;

  localparam logic [127:0] ALPHA_J = {8'h26, 8'h13, 8'h87, 8'hcd, 8'he8, 8'h74, 8'h3a, 8'h1d,
                                      8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  localparam logic [127:0] ALL_01  = {16{8'h01}};
  localparam logic [127:0] ALL_05  = {16{8'h05}};

  logic               clk = 1'b0;
  logic               rst;
  logic [8*LANES-1:0] in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [8*NSYM-1:0]  out_syn;
  logic               out_err;
  logic [CNT_W-1:0]   out_beats;
  logic               out_valid;
  logic               out_ready;

  always #5 clk = ~clk;

  rs_syndrome_par #(.LANES(LANES), .NSYM(NSYM), .FCR(0), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_syn   (out_syn),
    .out_err   (out_err),
    .out_beats (out_beats),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [8*NSYM-1:0] syn;
    logic              err;
    logic [CNT_W-1:0]  beats;
  } res_t;

  res_t       exp_q[$];
  logic [7:0] cw[$];
  logic [7:0] g[0:16];
  int         checks = 0;
  int         passed = 0;
  int         cyc = 0;
  bit         rand_rdy = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic res_t mk(input logic [127:0] syn, input logic err, input int beats);
    res_t r;
    r.syn   = syn;
    r.err   = err;
    r.beats = CNT_W'(beats);
    return r;
  endfunction

  function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      y = y >> 1;
      x = x[7] ? (8'({x, 1'b0}) ^ 8'h1d) : 8'({x, 1'b0});
    end
    return p;
  endfunction

  // Symbol-serial Horner evaluation of the whole byte stream at alpha^j.
  function automatic res_t model();
    res_t r;
    logic [7:0] root, s;
    int nb;
    nb = cw.size() / LANES;
    r = '0;
    root = 8'h01;
    for (int j = 0; j < NSYM; j++) begin
      s = 0;
      foreach (cw[i]) s = tmul(s, root) ^ cw[i];
      r.syn[8*j +: 8] = s;
      root = tmul(root, 8'h02);
    end
    r.err   = |r.syn;
    r.beats = CNT_W'(nb > 255 ? 255 : nb);
    return r;
  endfunction

  // Systematic RS(255,239) encoder, generator roots alpha^0..alpha^15,
  // front-padded with one zero byte to fill 16 beats.
  task automatic encode_rs();
    logic [7:0] a, m, fb;
    logic [7:0] rem[16];
    for (int i = 0; i <= 16; i++) g[i] = 0;
    g[0] = 1; a = 1;
    for (int j = 0; j < 16; j++) begin
      for (int i = j + 1; i >= 1; i--) g[i] = g[i-1] ^ tmul(g[i], a);
      g[0] = tmul(g[0], a);
      a = tmul(a, 8'h02);
    end
    for (int i = 0; i < 16; i++) rem[i] = 0;
    cw.delete();
    cw.push_back(8'h00);
    for (int n = 0; n < 239; n++) begin
      m = 8'($urandom);
      cw.push_back(m);
      fb = m ^ rem[15];
      for (int i = 15; i >= 1; i--) rem[i] = rem[i-1] ^ tmul(fb, g[i]);
      rem[0] = tmul(fb, g[0]);
    end
    for (int i = 15; i >= 0; i--) cw.push_back(rem[i]);
  endtask

  task automatic make_zero(input int nb);
    cw.delete();
    repeat (nb * LANES) cw.push_back(8'h00);
  endtask

  task automatic make_rand(input int nb);
    cw.delete();
    repeat (nb * LANES) cw.push_back(8'($urandom));
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat transferred.
  task automatic drive_beat(input logic [8*LANES-1:0] d, input logic last);
    int guard;
    in_data = d; in_last = last; in_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 2000) begin
        $display("FAIL in_ready_timeout: got stalled expected transfer");
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send(input res_t e, input int gap_max);
    logic [8*LANES-1:0] d;
    int nb, n;
    exp_q.push_back(e);
    nb = cw.size() / LANES;
    for (int b = 0; b < nb; b++) begin
      for (int l = 0; l < LANES; l++) d[8*l +: 8] = cw[b*LANES + l];
      drive_beat(d, b == nb - 1);
      if (gap_max > 0) begin
        n = $urandom_range(0, gap_max);
        if (n > 0) begin
          repeat (n) @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    check("drain_pending", exp_q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every consumed result against the scoreboard head.
  always @(negedge clk) begin
    res_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_syn", out_syn, e.syn);
        check("out_err", out_err, e.err);
        check("out_beats", out_beats, e.beats);
      end
    end
  end

  initial begin
    int t0;
    logic [8*LANES-1:0] d;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_syn", out_syn, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_beats", out_beats, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // all-zero codeword
    make_zero(16);
    send(mk(0, 0, 16), 0);

    // valid codeword, then degree-0 flip
    encode_rs();
    send(mk(0, 0, 16), 0);
    cw[255] = cw[255] ^ 8'h01;
    send(mk(ALL_01, 1, 16), 0);

    // single error 0x01 at degree 1
    make_zero(16);
    cw[254] = 8'h01;
    send(mk(ALPHA_J, 1, 16), 0);
    wait_drain();

    // single-beat codewords back-to-back: one beat per cycle
    make_zero(1);
    cw[15] = 8'h05;
    t0 = cyc;
    repeat (3) send(mk(ALL_05, 1, 1), 0);
    check("b2b_cycles", cyc - t0, 3);
    wait_drain();

    // consumer stall: second codeword must wait with no beat lost
    out_ready = 1'b0;
    fork
      begin
        int gd;
        gd = 0;
        while (!out_valid && gd < 200) begin
          @(negedge clk);
          gd++;
        end
        check("stall_in_ready", in_ready, 0);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    make_rand(2);
    send(model(), 0);
    make_rand(3);
    send(model(), 0);
    wait_drain();

    // beat counter saturation (300 beats)
    make_zero(300);
    cw[cw.size() - 1] = 8'h01;
    send(mk(ALL_01, 1, 255), 0);
    wait_drain();

    // reset after 7 beats of a partial codeword
    for (int b = 0; b < 7; b++) begin
      for (int l = 0; l < LANES; l++) d[8*l +: 8] = 8'($urandom);
      drive_beat(d, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    encode_rs();
    send(mk(0, 0, 16), 0);
    wait_drain();

    // random lengths, input gaps and consumer back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      make_rand($urandom_range(1, 17));
      send(model(), 3);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #3;
    out_ready = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
